// File: rtl/biu_lsu.sv
// biu_lsu: bus interface unit between the PRV332 core (EX0/MEM0/MEM1) and a
// 32-bit word-aligned request/acknowledge system bus.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, opc_biu, addr, wdata  core request (sampled only in IDLE)
//   ld_unsigned                  1 = zero-extend loads, 0 = sign-extend
//   busy, rdy_biu, err_biu      status; rdy_biu/err_biu are one-cycle pulses
//   rdata                        extended load result, held until next start
//   bus_req, bus_wr, bus_addr, bus_be, bus_wdata   beat request to the bus
//   bus_ack, bus_err, bus_rdata                    beat response from the bus
module biu_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  opc_biu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ld_unsigned,
  output logic        busy,
  output logic        rdy_biu,
  output logic        err_biu,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     off_q, off_d;
  logic [2:0]     opc_q, opc_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           uns_q, uns_d;
  logic [31:0]    rd0_q, rd0_d;
  logic [31:0]    rdata_d, baddr_d, bwd_d;
  logic           err_d, req_d, wr_d, busy_d, rdy_d;
  logic [3:0]     be_d;

  // Lane geometry: from the live request in IDLE, from latched fields otherwise.
  logic [1:0]  src_off;
  logic [2:0]  src_n;
  logic [31:0] src_wd;
  logic [7:0]  lane_mask;
  logic [63:0] wide_wd;
  logic        split;

  always_comb begin
    src_off = off_q;
    src_wd  = wdata_q;
    case (state_q == IDLE ? opc_biu[1:0] : opc_q[1:0])
      2'b01:   src_n = 3'd1;
      2'b10:   src_n = 3'd2;
      default: src_n = 3'd4;
    endcase
    if (state_q == IDLE) begin
      src_off = addr[1:0];
      src_wd  = wdata;
    end
    // Low nibble = beat 0 enables, high nibble = beat 1 enables.
    lane_mask = ((8'd1 << src_n) - 8'd1) << src_off;
    wide_wd   = {32'd0, src_wd} << {src_off, 3'b000};
  end

  assign split = |lane_mask[7:4];

  // Read assembly from the masked beat words.
  logic [31:0] be_mask, lane_rd, w0, w1, raw, ld_ext;

  always_comb begin
    be_mask = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
    lane_rd = bus_rdata & be_mask;
    w0      = (state_q == BEAT0) ? lane_rd : rd0_q;
    w1      = (state_q == BEAT1) ? lane_rd : 32'd0;
    raw     = 32'({w1, w0} >> {off_q, 3'b000});
    case (opc_q[1:0])
      2'b01:   ld_ext = uns_q ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b10:   ld_ext = uns_q ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ld_ext = raw;
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = TO_EN && (cnt_q == CW'(TO_LAST));

  // Next-state and registered-output logic.
  logic finish, fin_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    opc_d   = opc_q;
    wdata_d = wdata_q;
    uns_d   = uns_q;
    rd0_d   = rd0_q;
    rdata_d = rdata;
    err_d   = 1'b0;
    req_d   = bus_req;
    wr_d    = bus_wr;
    baddr_d = bus_addr;
    be_d    = bus_be;
    bwd_d   = bus_wdata;
    finish  = 1'b0;
    fin_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rdata_d = 32'd0;
          if (opc_biu[1:0] == 2'b00) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            off_d   = addr[1:0];
            opc_d   = opc_biu;
            wdata_d = wdata;
            uns_d   = ld_unsigned;
            cnt_d   = '0;
            state_d = BEAT0;
            req_d   = 1'b1;
            wr_d    = ~opc_biu[2];
            baddr_d = {addr[31:2], 2'b00};
            be_d    = lane_mask[3:0];
            bwd_d   = wide_wd[31:0];
          end
        end
      end
      BEAT0: begin
        if (bus_ack) begin
          if (bus_err) begin
            finish  = 1'b1;
            fin_err = 1'b1;
          end else if (split) begin
            // bus_req stays high: back-to-back second beat.
            rd0_d   = lane_rd;
            cnt_d   = '0;
            state_d = BEAT1;
            baddr_d = bus_addr + 32'd4;
            be_d    = lane_mask[7:4];
            bwd_d   = wide_wd[63:32];
          end else begin
            finish = 1'b1;
          end
        end else if (timeout_hit) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BEAT1: begin
        if (bus_ack) begin
          finish  = 1'b1;
          fin_err = bus_err;
        end else if (timeout_hit) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      req_d   = 1'b0;
      wr_d    = 1'b0;
      baddr_d = 32'd0;
      be_d    = 4'd0;
      bwd_d   = 32'd0;
      err_d   = fin_err;
      rdata_d = (fin_err || !opc_q[2]) ? 32'd0 : ld_ext;
    end

    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= 2'd0;
      opc_q     <= 3'd0;
      wdata_q   <= 32'd0;
      uns_q     <= 1'b0;
      rd0_q     <= 32'd0;
      busy      <= 1'b0;
      rdy_biu   <= 1'b0;
      err_biu   <= 1'b0;
      rdata     <= 32'd0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      opc_q     <= opc_d;
      wdata_q   <= wdata_d;
      uns_q     <= uns_d;
      rd0_q     <= rd0_d;
      busy      <= busy_d;
      rdy_biu   <= rdy_d;
      err_biu   <= err_d;
      rdata     <= rdata_d;
      bus_req   <= req_d;
      bus_wr    <= wr_d;
      bus_addr  <= baddr_d;
      bus_be    <= be_d;
      bus_wdata <= bwd_d;
    end
  end

endmodule

// File: tb/tb_biu_lsu.sv
// Self-checking bench for biu_lsu (TIMEOUT = 8): table vectors, reset and
// misuse sequences, then randomized transactions against a byte-level model.
module tb_biu_lsu;

  logic        clk, rst_n, start, ld_unsigned;
  logic [2:0]  opc_biu;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic        busy, rdy_biu, err_biu, bus_req, bus_wr, bus_ack, bus_err;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_err = 0;

  biu_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opc_biu(opc_biu), .addr(addr),
    .wdata(wdata), .ld_unsigned(ld_unsigned), .busy(busy), .rdy_biu(rdy_biu),
    .err_biu(err_biu), .rdata(rdata), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Byte-level model: byte k of the access lives at byte address a+k.
  task automatic model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] wd,
                       input logic uns, input logic [31:0] m0, input logic [31:0] m1,
                       output logic [3:0] be0, output logic [3:0] be1,
                       output logic [31:0] wd0, output logic [31:0] wd1,
                       output logic sp, output logic [31:0] res);
    int n, o, pos;
    n = (opc[1:0] == 2'b01) ? 1 : (opc[1:0] == 2'b10) ? 2 : 4;
    o = int'(a[1:0]);
    be0 = 4'd0; be1 = 4'd0; wd0 = 32'd0; wd1 = 32'd0; res = 32'd0;
    for (int k = 0; k < n; k++) begin
      pos = o + k;
      if (pos < 4) begin
        be0[pos] = 1'b1;
        wd0[pos*8 +: 8] = wd[k*8 +: 8];
        res[k*8 +: 8]   = m0[pos*8 +: 8];
      end else begin
        be1[pos-4] = 1'b1;
        wd1[(pos-4)*8 +: 8] = wd[k*8 +: 8];
        res[k*8 +: 8]       = m1[(pos-4)*8 +: 8];
      end
    end
    sp = (o + n > 4);
    if (!uns && res[8*n-1])
      for (int k = n; k < 4; k++) res[k*8 +: 8] = 8'hFF;
  endtask

  // One transaction: issue start, play the bus slave, check beats and result.
  task automatic do_txn(input string tag, input logic [2:0] opc, input logic [31:0] a,
                        input logic [31:0] wd, input logic uns, input int d0, input int d1,
                        input logic [31:0] m0, input logic [31:0] m1, input logic e0,
                        input logic [31:0] x_rdata, input logic x_err, input int x_lat,
                        input bit noise);
    logic [3:0]  be0, be1, xbe;
    logic [31:0] wd0, wd1, res, a0, xa, xw;
    logic        sp;
    int b = 0, wc = 0, cyc = 1, nreq = 0, xreq = 0, dl;
    bit done = 0;
    model(opc, a, wd, uns, m0, m1, be0, be1, wd0, wd1, sp, res);
    a0 = {a[31:2], 2'b00};
    if (opc[1:0] != 2'b00) begin
      xreq = (d0 >= 8) ? 8 : d0 + 1;
      if (d0 < 8 && !e0 && sp) xreq += (d1 >= 8) ? 8 : d1 + 1;
    end
    @(negedge clk);
    start = 1'b1; opc_biu = opc; addr = a; wdata = wd; ld_unsigned = uns;
    @(negedge clk);
    start = 1'b0; addr = $urandom; wdata = $urandom;
    opc_biu = 3'($urandom); ld_unsigned = 1'($urandom);
    while (!done && cyc < 40) begin
      bus_ack = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
      if (noise) begin
        start = 1'($urandom); opc_biu = 3'($urandom); addr = $urandom;
        wdata = $urandom; ld_unsigned = 1'($urandom);
      end
      chk($sformatf("%s busy c%0d", tag, cyc), 128'(busy), 128'(1'b1));
      if (rdy_biu) begin
        start = 1'b0;
        chk($sformatf("%s result {err,rdata,req}", tag),
            128'({err_biu, rdata, bus_req}), 128'({x_err, x_rdata, 1'b0}));
        chk($sformatf("%s latency", tag), 128'(cyc), 128'(x_lat));
        chk($sformatf("%s req_cycles", tag), 128'(nreq), 128'(xreq));
        done = 1;
      end else if (bus_req) begin
        nreq++;
        if (b > 1) begin
          chk($sformatf("%s extra beat", tag), 128'(b), 128'(1));
        end else begin
          xbe = (b == 0) ? be0 : be1;
          xa  = (b == 0) ? a0 : a0 + 32'd4;
          xw  = (b == 0) ? wd0 : wd1;
          chk($sformatf("%s beat%0d {wr,addr,be,wdata}", tag, b),
              128'({bus_wr, bus_addr, bus_be, bus_wdata & bmask(xbe)}),
              128'({~opc[2], xa, xbe, xw}));
          dl = (b == 0) ? d0 : d1;
          if (wc == dl) begin
            bus_ack = 1'b1;
            bus_rdata = (b == 0) ? m0 : m1;
            bus_err = (b == 0) && e0;
            b++; wc = 0;
          end else begin
            wc++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus_ack = 1'b0; bus_err = 1'b0; start = 1'b0;
    if (!done) chk($sformatf("%s rdy_biu never seen", tag), 128'(0), 128'(1));
    chk($sformatf("%s idle {busy,rdy,req,rdata}", tag),
        128'({busy, rdy_biu, bus_req, rdata}), 128'({3'b000, x_rdata}));
  endtask

  typedef struct {
    logic [2:0]  opc;
    logic [31:0] a, wd;
    logic        uns;
    int          d0, d1;
    logic [31:0] m0, m1;
    logic        e0;
    logic [31:0] x_rdata;
    logic        x_err;
    int          x_lat;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [2:0]  opc;
    logic [31:0] a, wd, m0, m1, res, xr, wd0, wd1;
    logic [3:0]  be0, be1;
    logic        uns, e0, sp, xe;
    int          d0, d1, lat;

    rst_n = 1'b0; start = 1'b0; opc_biu = 3'd0; addr = 32'd0; wdata = 32'd0;
    ld_unsigned = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset outputs", 128'({busy, rdy_biu, err_biu, rdata, bus_req, bus_wr, bus_addr,
                               bus_be, bus_wdata}), 128'(0));
    rst_n = 1'b1;

    //        opc     addr          wdata         uns d0  d1  m0            m1            e0    x_rdata       err   lat
    vt[0]  = '{3'b111, 32'h00001000, 32'h0,        1'b0, 0, 0, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 2};
    vt[1]  = '{3'b101, 32'h00002001, 32'h0,        1'b0, 0, 0, 32'h1234F680, 32'h0,        1'b0, 32'hFFFFFFF6, 1'b0, 2};
    vt[2]  = '{3'b101, 32'h00002001, 32'h0,        1'b1, 0, 0, 32'h1234F680, 32'h0,        1'b0, 32'h000000F6, 1'b0, 2};
    vt[3]  = '{3'b110, 32'h00001003, 32'h0,        1'b0, 0, 0, 32'h11223344, 32'h55667788, 1'b0, 32'hFFFF8811, 1'b0, 3};
    vt[4]  = '{3'b011, 32'h00001002, 32'hAABBCCDD, 1'b0, 0, 0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 3};
    vt[5]  = '{3'b010, 32'hFFFFFFFF, 32'h00001234, 1'b0, 0, 0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 3};
    vt[6]  = '{3'b111, 32'h00003000, 32'h0,        1'b0, 0, 0, 32'h12345678, 32'h0,        1'b1, 32'h0,        1'b1, 2};
    vt[7]  = '{3'b110, 32'h00000003, 32'h0,        1'b0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 3};
    vt[8]  = '{3'b111, 32'h00005000, 32'h0,        1'b0, 99, 0, 32'h0,       32'h0,        1'b0, 32'h0,        1'b1, 9};
    vt[9]  = '{3'b100, 32'h00001000, 32'h0,        1'b0, 0, 0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[10] = '{3'b000, 32'h00001000, 32'h0,        1'b0, 0, 0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[11] = '{3'b101, 32'h00000002, 32'h0,        1'b1, 3, 0, 32'h00AB0000, 32'h0,        1'b0, 32'h000000AB, 1'b0, 5};
    vt[12] = '{3'b111, 32'h00001001, 32'h0,        1'b0, 2, 4, 32'hA1B2C3D4, 32'h11223344, 1'b0, 32'h44A1B2C3, 1'b0, 9};
    vt[13] = '{3'b111, 32'h00007000, 32'h0,        1'b0, 7, 0, 32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 9};
    vt[14] = '{3'b111, 32'h00006002, 32'h0,        1'b0, 0, 99, 32'h01020304, 32'h0,       1'b0, 32'h0,        1'b1, 10};

    for (int i = 0; i < 15; i++)
      do_txn($sformatf("vec%0d", i), vt[i].opc, vt[i].a, vt[i].wd, vt[i].uns, vt[i].d0,
             vt[i].d1, vt[i].m0, vt[i].m1, vt[i].e0, vt[i].x_rdata, vt[i].x_err,
             vt[i].x_lat, (i % 2) == 1);

    // Reset pulled during a BEAT0 wait abandons the access.
    @(negedge clk);
    start = 1'b1; opc_biu = 3'b111; addr = 32'h00004000;
    @(negedge clk);
    start = 1'b0;
    chk("rst seq req up", 128'(bus_req), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst mid-beat", 128'({bus_req, busy, rdy_biu, err_biu, bus_be}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after rst idle", 128'({bus_req, busy, rdy_biu}), 128'(0));
    do_txn("post_rst", vt[0].opc, vt[0].a, vt[0].wd, vt[0].uns, 0, 0, vt[0].m0, 32'h0,
           1'b0, vt[0].x_rdata, 1'b0, 2, 1'b0);

    // Randomized transactions against the byte-level model.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) opc = {1'($urandom), 2'b00};
      else opc = {1'($urandom), 2'($urandom_range(1, 3))};
      a = $urandom; wd = $urandom; uns = 1'($urandom);
      m0 = $urandom; m1 = $urandom;
      d0 = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 3);
      d1 = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 3);
      e0 = ($urandom_range(0, 7) == 0);
      model(opc, a, wd, uns, m0, m1, be0, be1, wd0, wd1, sp, res);
      xr = 32'd0; xe = 1'b1;
      if (opc[1:0] == 2'b00) lat = 1;
      else if (d0 >= 8) lat = 9;
      else if (e0) lat = d0 + 2;
      else if (!sp) begin lat = d0 + 2; xe = 1'b0; xr = opc[2] ? res : 32'd0; end
      else if (d1 >= 8) lat = d0 + 10;
      else begin lat = d0 + d1 + 3; xe = 1'b0; xr = opc[2] ? res : 32'd0; end
      do_txn($sformatf("rnd%0d", i), opc, a, wd, uns, d0, d1, m0, m1, e0, xr, xe, lat, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
